// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD adder: controller states and BCD constants.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } bcd_state_t;

  localparam logic [3:0] BCD_MAX_DIGIT  = 4'd9;
  localparam logic [3:0] BCD_CORRECTION = 4'd6;

endpackage

// File: rtl/bcd_digit_cell.sv
// Single-digit BCD adder: binary add of two digits plus carry, then decimal correction.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       digit_err
);

  logic [4:0] raw;
  logic [4:0] corrected;

  // Raw sum, decimal correction when the result leaves the 0..9 range, and digit validity flag.
  always_comb begin
    raw       = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    corrected = raw + {1'b0, BCD_CORRECTION};
    sum       = raw[3:0];
    cout      = 1'b0;
    if (raw > {1'b0, BCD_MAX_DIGIT}) begin
      sum  = corrected[3:0];
      cout = 1'b1;
    end
    digit_err = (a > BCD_MAX_DIGIT) || (b > BCD_MAX_DIGIT);
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Serial BCD adder controller: one digit per clock through a single shared digit cell.
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4*NDIG-1:0] A,
  input  logic [4*NDIG-1:0] B,
  input  logic              Cin,
  output logic              busy,
  output logic              done,
  output logic [4*NDIG-1:0] Sum,
  output logic              Cout,
  output logic              err
);

  localparam int W     = 4 * NDIG;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

  bcd_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             err_q, err_d;

  logic [3:0] dig_a;
  logic [3:0] dig_b;
  logic [3:0] cell_sum;
  logic       cell_cout;
  logic       cell_err;

  // Select the operand digits addressed by the current index.
  always_comb begin
    dig_a = a_q[4*int'(idx_q) +: 4];
    dig_b = b_q[4*int'(idx_q) +: 4];
  end

  bcd_digit_cell u_cell (
    .a         (dig_a),
    .b         (dig_b),
    .cin       (carry_q),
    .sum       (cell_sum),
    .cout      (cell_cout),
    .digit_err (cell_err)
  );

  // Next-state logic: accept in IDLE/DONE, step one digit per cycle in ADD.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          err_d   = 1'b0;
          state_d = ST_ADD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADD: begin
        sum_d[4*int'(idx_q) +: 4] = cell_sum;
        carry_d = cell_cout;
        if (cell_err) begin
          err_d = 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          cout_d  = cell_cout;
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous reset that clears all datapath state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

  // Status decode and registered result outputs.
  always_comb begin
    busy = (state_q == ST_ADD);
    done = (state_q == ST_DONE);
    Sum  = sum_q;
    Cout = cout_q;
    err  = err_q;
  end

endmodule

// File: doc/bcd_serial_add_ctrl.md
BCD_SERIAL_ADD_CTRL -- requirements
Module: bcd_serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter NDIG, default 4, giving the number of BCD digits per operand (legal range 1..8).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition.
REQ-005 The block SHALL have ports A and B, input, 4*NDIG bits each: packed BCD operands, digit 0 in bits [3:0].
REQ-006 The block SHALL have port Cin, input, 1 bit: initial decimal carry-in.
REQ-007 The block SHALL have port busy, output, 1 bit: high while digits are being processed.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-009 The block SHALL have port Sum, output, 4*NDIG bits: packed BCD result.
REQ-010 The block SHALL have port Cout, output, 1 bit: decimal carry out of the top digit.
REQ-011 The block SHALL have port err, output, 1 bit: an operand digit exceeded 9.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, ADD and DONE.
REQ-013 In IDLE or DONE, start=1 at an edge SHALL register A, B and Cin, clear the digit index to 0, clear Sum, Cout and err, and move to ADD.
REQ-014 In ADD, each edge SHALL add operand digit[idx] plus the carry register through one digit adder, write Sum digit[idx], update the carry register, and increment idx.
REQ-015 The digit adder SHALL form a 5-bit raw sum; if the raw sum > 9, the digit result SHALL be (raw + 6) mod 16 with carry 1, else raw with carry 0.
REQ-016 The edge that processes digit NDIG-1 SHALL move the FSM to DONE and load Cout from the final carry.
REQ-017 done SHALL be 1 only in DONE; DONE SHALL return to IDLE on the next edge unless start=1 (REQ-013).
REQ-018 Latency SHALL be exactly NDIG+1 edges from the start-accept edge to the cycle in which done=1.
REQ-019 busy SHALL be 1 exactly in ADD.
REQ-020 start while in ADD SHALL be ignored; registered operands SHALL not change.
REQ-021 err SHALL be set in ADD when a processed A or B digit is greater than 9, SHALL stay set until the next accepted start, and SHALL not alter the arithmetic of REQ-015.
REQ-022 Sum, Cout and err SHALL hold their values from DONE through IDLE until the next accepted start.
REQ-023 Changes on A, B or Cin after the accept edge SHALL not affect the result.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE and set idx=0, the carry register to 0, busy=0, done=0, Sum=0, Cout=0 and err=0; rst SHALL take priority over start.
REQ-025 Reset asserted mid-operation SHALL abort the addition with no done pulse; operation SHALL resume only on a new start after rst is released.

Structure
REQ-026 The FSM state encodings and the BCD constants (max digit 9, correction 6) SHALL reside in a shared package bcd_pkg.
REQ-027 The per-digit combinational add/correct SHALL be a sub-module bcd_digit_cell, instantiated exactly once and time-shared across all digits.

Verification
REQ-028 NDIG=4, A=0x1234, B=0x5678, Cin=0, start pulsed -> busy high for 4 cycles, done on cycle 5, Sum=0x6912, Cout=0, err=0.
REQ-029 A=0x9999, B=0x0001, Cin=0 -> Sum=0x0000, Cout=1.
REQ-030 A=0x0999, B=0x0000, Cin=1 -> Sum=0x1000, Cout=0.
REQ-031 start re-pulsed during ADD with different operands -> ignored, first result returned unchanged; start held in the DONE cycle -> a back-to-back second addition completes correctly.
REQ-032 rst pulsed on the second ADD cycle -> no done pulse, all outputs 0, next start with 0x0005+0x0005 -> Sum=0x0010.
REQ-033 A=0x00A0, B=0x0000 -> err=1 at done, Sum follows REQ-015 (digit 1 = 0x0, carry 1, Sum=0x0100).
